// File: rtl/spi_frame_unpack.sv
// Two-entry frame buffer that accepts DATA_W-bit frames from an SPI host
// data-out register and streams them out as NWORDS words of WORD_W bits,
// word 0 (bits [WORD_W-1:0]) first, under a valid/ready handshake.
// Frames arriving while both entries are occupied are dropped and counted.
module spi_frame_unpack #(
    parameter int DATA_W = 256,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_write,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              frame_first,
    output logic              frame_last,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic [7:0]        drop_cnt,
    output logic              busy
);

    localparam int NWORDS = DATA_W / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] frame_buf [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [IDX_W-1:0]  widx;

    logic              xfer;
    logic              pop;
    logic              push;
    logic              drop;
    logic              rd_ptr_inc;
    logic [IDX_W-1:0]  nidx;
    logic [DATA_W-1:0] head_frame;
    logic [DATA_W-1:0] next_frame;

    // A pop is the handshake on the last word; a full buffer still accepts a
    // frame on the same edge that frees an entry.
    assign xfer       = word_valid && word_ready;
    assign pop        = xfer && (widx == LAST_IDX);
    assign push       = data_write && ((count != 2'd2) || pop);
    assign drop       = data_write && (count == 2'd2) && !pop;
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign nidx       = widx + 1'b1;
    assign busy       = (count != 2'd0) || word_valid;

    // Select the head frame and the frame that follows it; the follower may be
    // arriving this very cycle, in which case it is taken straight from data_in.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
        head_frame = frame_buf[rd_ptr];
        next_frame = frame_buf[rd_ptr_inc];
        if (push && (wr_ptr == rd_ptr_inc)) begin
            next_frame = data_in;
        end
    end

    // Frame storage write port.
    // NOTE: the storage array has no reset; pointers and count make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            frame_buf[wr_ptr] <= data_in;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 1 bit.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag (a drop beats a same-cycle clear) and saturating drop count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Output FSM: loads one word per handshake, chaining frames without a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            word_out    <= '0;
            word_valid  <= 1'b0;
            frame_first <= 1'b0;
            frame_last  <= 1'b0;
            widx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != 2'd0) begin
                        word_out    <= head_frame[WORD_W-1:0];
                        word_valid  <= 1'b1;
                        frame_first <= 1'b1;
                        frame_last  <= (NWORDS == 1);
                        widx        <= '0;
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (!pop) begin
                            word_out    <= head_frame[int'(nidx)*WORD_W +: WORD_W];
                            frame_first <= 1'b0;
                            frame_last  <= (nidx == LAST_IDX);
                            widx        <= nidx;
                        end else if ((count == 2'd2) || push) begin
                            word_out    <= next_frame[WORD_W-1:0];
                            frame_first <= 1'b1;
                            frame_last  <= (NWORDS == 1);
                            widx        <= '0;
                        end else begin
                            word_valid  <= 1'b0;
                            frame_first <= 1'b0;
                            frame_last  <= 1'b0;
                            widx        <= '0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_unpack.sv
// Self-checking bench for spi_frame_unpack: a queue-of-frames model is checked
// against the DUT on every falling edge, and directed scenarios pin the model
// with hand-computed literal expectations.
module tb_spi_frame_unpack;

    localparam int DATA_W = 256;
    localparam int WORD_W = 16;
    localparam int NWORDS = DATA_W / WORD_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] data_in;
    logic              data_write;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic              frame_first;
    logic              frame_last;
    logic              overflow;
    logic              clr_ovf;
    logic [7:0]        drop_cnt;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    spi_frame_unpack #(.DATA_W(DATA_W), .WORD_W(WORD_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_in     (data_in),
        .data_write  (data_write),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .frame_first (frame_first),
        .frame_last  (frame_last),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame whose word k holds base + k.
    function automatic logic [DATA_W-1:0] make_frame(input logic [15:0] base);
        logic [DATA_W-1:0] f;
        for (int k = 0; k < NWORDS; k++) f[k*WORD_W +: WORD_W] = base + 16'(k);
        return f;
    endfunction

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] mq [$];
    logic [DATA_W-1:0] m_head;
    bit                m_valid = 0;
    int                m_k     = 0;
    bit                m_ovf   = 0;
    int                m_drops = 0;
    int                m_old_sz;
    bit                m_xfer, m_pop, m_drop;
    logic [15:0]       xfer_log [$];

    always @(negedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_valid = 0;
            m_k     = 0;
            m_ovf   = 0;
            m_drops = 0;
            check("rst_valid", word_valid, 0);
            check("rst_busy", busy, 0);
        end else begin
            check("valid", word_valid, m_valid);
            check("busy", busy, (mq.size() != 0) || m_valid);
            check("overflow", overflow, m_ovf);
            check("drop_cnt", drop_cnt, m_drops);
            if (m_valid) begin
                m_head = mq[0];
                check("word_out", word_out, m_head[m_k*WORD_W +: WORD_W]);
                check("frame_first", frame_first, m_k == 0);
                check("frame_last", frame_last, m_k == NWORDS - 1);
            end
            if (word_valid && word_ready) xfer_log.push_back(word_out);

            // Advance the model to the state after the coming rising edge.
            m_old_sz = mq.size();
            m_xfer   = m_valid && word_ready;
            m_pop    = m_xfer && (m_k == NWORDS - 1);
            m_drop   = data_write && !(m_old_sz < 2 || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (data_write && !m_drop) mq.push_back(data_in);
            if (m_drop) begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end else if (clr_ovf) begin
                m_ovf = 0;
            end
            if (!m_valid) begin
                if (m_old_sz > 0) begin
                    m_valid = 1;
                    m_k     = 0;
                end
            end else if (m_xfer) begin
                if (!m_pop)             m_k++;
                else if (mq.size() > 0) m_k = 0;
                else                    m_valid = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input logic [15:0] base);
        data_in    = make_frame(base);
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
    endtask

    initial begin
        bit found;
        reset_n    = 1'b0;
        data_in    = '0;
        data_write = 1'b0;
        word_ready = 1'b0;
        clr_ovf    = 1'b0;
        repeat (2) tick();
        check("reset_word_out", word_out, 0);
        check("reset_first", frame_first, 0);
        check("reset_last", frame_last, 0);
        check("reset_overflow", overflow, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single frame, always ready: latency and word order.
        word_ready = 1'b1;
        xfer_log.delete();
        write_frame(16'h0001);
        check("lat_edge_n", word_valid, 0);
        tick();
        check("lat_edge_n1", word_valid, 1);
        check("first_word", word_out, 16'h0001);
        check("first_flag", frame_first, 1);
        repeat (15) tick();
        check("last_word", word_out, 16'h0010);
        check("last_flag", frame_last, 1);
        check("last_not_first", frame_first, 0);
        tick();
        check("idle_after_frame", word_valid, 0);
        check("idle_busy", busy, 0);
        check("log1_size", xfer_log.size(), 16);
        for (int i = 0; i < xfer_log.size() && i < 16; i++)
            check("log1_word", xfer_log[i], 16'h0001 + 16'(i));

        // Ready toggling every cycle.
        word_ready = 1'b0;
        xfer_log.delete();
        write_frame(16'h0100);
        for (int i = 0; i < 40; i++) begin
            word_ready = ~word_ready;
            tick();
        end
        check("log2_size", xfer_log.size(), 16);
        for (int i = 0; i < xfer_log.size() && i < 16; i++)
            check("log2_word", xfer_log[i], 16'h0100 + 16'(i));

        // Three back-to-back strobes while stalled: third is dropped.
        word_ready = 1'b0;
        repeat (2) tick();
        xfer_log.delete();
        write_frame(16'h0200);
        write_frame(16'h0300);
        write_frame(16'h0400);
        repeat (3) tick();
        check("ovf_after_drop", overflow, 1);
        check("drop_cnt_1", drop_cnt, 1);
        word_ready = 1'b1;
        repeat (34) tick();
        check("log3_size", xfer_log.size(), 32);
        for (int i = 0; i < xfer_log.size() && i < 32; i++)
            check("log3_word", xfer_log[i], (i < 16) ? 16'h0200 + 16'(i) : 16'h0300 + 16'(i - 16));
        check("idle_after_two", word_valid, 0);

        // Full buffer, write on the edge that transfers the last word.
        clr_ovf = 1'b1;
        tick();
        clr_ovf    = 1'b0;
        word_ready = 1'b0;
        write_frame(16'h0500);
        write_frame(16'h0600);
        xfer_log.delete();
        word_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (word_valid && frame_last && word_out == 16'h050F) found = 1;
        end
        check("wait_last_word", found, 1);
        write_frame(16'h0700);
        check("no_ovf_on_pop", overflow, 0);
        check("drop_cnt_kept", drop_cnt, 1);
        repeat (40) tick();
        check("log4_size", xfer_log.size(), 48);
        for (int i = 0; i < xfer_log.size() && i < 48; i++)
            check("log4_word", xfer_log[i], 16'h0500 + 16'((i / 16) * 16'h0100) + 16'(i % 16));

        // Drop-count saturation and overflow clearing.
        word_ready = 1'b0;
        write_frame(16'h0800);
        write_frame(16'h0900);
        data_write = 1'b1;
        repeat (300) tick();
        data_write = 1'b0;
        tick();
        check("drop_saturated", drop_cnt, 8'd255);
        check("ovf_set", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);
        check("drop_cnt_after_clr", drop_cnt, 8'd255);
        clr_ovf    = 1'b1;
        data_write = 1'b1;
        tick();
        clr_ovf    = 1'b0;
        data_write = 1'b0;
        check("ovf_set_wins", overflow, 1);

        // Asynchronous reset while word 7 is pending.
        word_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (word_valid && word_out == 16'h0807) found = 1;
        end
        check("wait_word7", found, 1);
        word_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_word_out", word_out, 0);
        check("arst_valid", word_valid, 0);
        check("arst_first", frame_first, 0);
        check("arst_last", frame_last, 0);
        check("arst_overflow", overflow, 0);
        check("arst_drop_cnt", drop_cnt, 0);
        check("arst_busy", busy, 0);
        tick();
        reset_n    = 1'b1;
        word_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_quiet", word_valid, 0);
        end
        xfer_log.delete();
        write_frame(16'h0A00);
        repeat (18) tick();
        check("log5_size", xfer_log.size(), 16);
        if (xfer_log.size() > 0) check("log5_first", xfer_log[0], 16'h0A00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_frame_unpack.md
SPI_FRAME_UNPACK -- requirements
Module: spi_frame_unpack

Interface
REQ-001 Parameter DATA_W, default 256, SHALL set the frame width in bits; it SHALL be a multiple of WORD_W.
REQ-002 Parameter WORD_W, default 16, SHALL set the output word width; NWORDS = DATA_W/WORD_W (default 16).
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RESET_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 DATA_IN  input  DATA_W  SHALL be the frame from the SPI host data-out register; bit 0 is the first bit received.
REQ-006 DATA_WRITE  input  1  SHALL be the one-cycle strobe marking DATA_IN valid.
REQ-007 WORD_OUT  output  WORD_W  SHALL be the current output word.
REQ-008 WORD_VALID  output  1  SHALL indicate that WORD_OUT holds a word not yet transferred.
REQ-009 WORD_READY  input  1  SHALL be the downstream acceptance signal.
REQ-010 FRAME_FIRST / FRAME_LAST  output  1 each  SHALL mark word 0 / word NWORDS-1 of a frame, qualified by WORD_VALID.
REQ-011 OVERFLOW  output  1  SHALL be a sticky flag set when a frame is dropped.
REQ-012 CLR_OVF  input  1  SHALL clear OVERFLOW.
REQ-013 DROP_CNT  output  8  SHALL be a saturating count of dropped frames.
REQ-014 BUSY  output  1  SHALL be high while any frame is buffered or being streamed.

Function
REQ-015 Frame buffer: 2 entries of DATA_W bits; write pointer, read pointer and a 0..2 occupancy count.
REQ-016 DATA_WRITE with count < 2: DATA_IN stored at the write pointer on that edge; count+1.
REQ-017 DATA_WRITE with count == 2 and no pop in the same cycle: frame dropped, buffer unchanged, OVERFLOW <= 1, DROP_CNT +1, saturating at 255.
REQ-018 DATA_WRITE with count == 2 and a pop (last-word transfer) in the same cycle: frame accepted, count stays 2, no overflow.
REQ-019 DATA_WRITE strobes on consecutive cycles: each strobe is a separate frame.
REQ-020 FSM states: IDLE and STREAM.
  - IDLE: WORD_VALID = 0.
  - IDLE -> STREAM: on the first edge with count > 0; the output register loads word 0 of the head frame, WORD_VALID <= 1.
REQ-021 Latency: DATA_WRITE at edge n into an empty buffer in IDLE -> WORD_VALID high after edge n+1.
REQ-022 Word order: word k = head frame bits [k*WORD_W+WORD_W-1 : k*WORD_W], k = 0..NWORDS-1 ascending.
REQ-023 Transfer occurs on an edge with WORD_VALID && WORD_READY; WORD_OUT, FRAME_FIRST and FRAME_LAST SHALL hold stable while WORD_VALID && !WORD_READY.
REQ-024 Transfer of word k < NWORDS-1: the next edge loads word k+1 with WORD_VALID kept high, giving 1 word/cycle with no bubble.
REQ-025 Transfer of word NWORDS-1: frame popped (read pointer +1, count-1).
  - If another frame remains (counting a same-cycle write), load its word 0 with WORD_VALID kept high and stay in STREAM.
  - Otherwise WORD_VALID <= 0 and go to IDLE.
REQ-026 Pointers SHALL wrap modulo 2; count SHALL never exceed 2 or go below 0.
REQ-027 CLR_OVF clears OVERFLOW only; DROP_CNT is unaffected. If CLR_OVF and a drop occur in the same cycle, set wins.
REQ-028 BUSY = (count != 0) || WORD_VALID.

Reset
REQ-029 RESET_N low SHALL immediately force:
  - WORD_OUT = 0, WORD_VALID = 0, FRAME_FIRST = 0, FRAME_LAST = 0;
  - OVERFLOW = 0, DROP_CNT = 0, BUSY = 0;
  - pointers and count = 0, FSM = IDLE.
  Buffer contents are don't-care.
REQ-030 Reset asserted mid-frame SHALL discard all buffered and partially streamed frames. After release, no word SHALL appear until a new DATA_WRITE.

Verification
REQ-031 One frame with DATA_IN[15:0]=16'h0001 ... [255:240]=16'h0010, WORD_READY=1 -> WORD_OUT = 0001..0010 on 16 consecutive cycles; FRAME_FIRST with 0001, FRAME_LAST with 0010; WORD_VALID first high at edge n+1.
REQ-032 WORD_READY toggled 1/0 every cycle during a frame -> every word appears exactly once, in order, held while not ready.
REQ-033 Three DATA_WRITE strobes on consecutive cycles with WORD_READY=0 -> frames 1 and 2 buffered, frame 3 dropped, OVERFLOW=1, DROP_CNT=1; then WORD_READY=1 -> 32 words of frames 1 and 2 back-to-back.
REQ-034 Buffer full and DATA_WRITE on the edge that transfers word 15 -> frame accepted, OVERFLOW stays 0, the new frame streams after the pending one.
REQ-035 300 drops -> DROP_CNT = 255; CLR_OVF pulse -> OVERFLOW=0, DROP_CNT still 255; CLR_OVF on the same cycle as a drop -> OVERFLOW=1.
REQ-036 RESET_N pulsed low while word 7 is pending -> all outputs 0 asynchronously; after release, no WORD_VALID until the next DATA_WRITE.
